seven_segment_scanner: RTL and testbench

Downstream consumer of the four per-digit seven-segment update stages. Takes the four 8-bit segment registers (bit 7 = decimal point, bits 6:0 = segments g..a) and time-multiplexes them onto one shared 8-bit segment bus with a one-hot digit select. Applies anti-ghosting blanking at each digit change and 16-step brightness PWM. Latches a tear-free snapshot of all four digits once per frame.

---
 rtl/seven_segment_pkg.sv | 8 +
 rtl/seven_segment_slot_timer.sv | 66 ++++++
 rtl/seven_segment_scanner.sv | 104 ++++++++++
 tb/tb_seven_segment_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment scanner and its slot timer.
package seven_segment_pkg;
  localparam int NR_OF_DIGITS = 4;
  localparam int DIGIT_W      = $clog2(NR_OF_DIGITS);
  localparam int SEG_DP_BIT   = 7;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE, DARK} state_e;
endpackage

// File: rtl/seven_segment_slot_timer.sv
// Slot/phase/digit counters for the scanner; held at zero while not running.
module seven_segment_slot_timer
  import seven_segment_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_i,
  output logic               slotStart_o,
  output logic               slotLast_o,
  output logic               frameWrap_o,
  output logic               blankLast_o,
  output logic               phaseLast_o,
  output logic [3:0]         phase_o,
  output logic [DIGIT_W-1:0] digit_o
);
  localparam int PHASE_CYCLES = DIGIT_CYCLES / 16;
  localparam int SW = $clog2(DIGIT_CYCLES);
  localparam int PW = $clog2(PHASE_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);

  logic [SW-1:0]      slotCnt_q, slotCnt_d;
  logic [PW-1:0]      phaseCnt_q, phaseCnt_d;
  logic [3:0]         phase_q, phase_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;

  // Lookahead flags: each is true in the last cycle before the event edge.
  assign slotStart_o = (slotCnt_q == '0);
  assign slotLast_o  = (slotCnt_q == SLOT_LAST);
  assign blankLast_o = (slotCnt_q == BLANK_LAST);
  assign phaseLast_o = (phaseCnt_q == PHASE_LAST);
  assign frameWrap_o = slotLast_o && (digit_q == DIGIT_W'(NR_OF_DIGITS - 1));
  assign phase_o     = phase_q;
  assign digit_o     = digit_q;

  always_comb begin
    slotCnt_d  = '0;
    phaseCnt_d = '0;
    phase_d    = '0;
    digit_d    = '0;
    if (run_i) begin
      slotCnt_d  = slotLast_o ? '0 : slotCnt_q + 1'b1;
      phaseCnt_d = (slotLast_o || phaseLast_o) ? '0 : phaseCnt_q + 1'b1;
      phase_d    = slotLast_o ? 4'd0 : (phaseLast_o ? phase_q + 4'd1 : phase_q);
      digit_d    = slotLast_o ? digit_q + 1'b1 : digit_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slotCnt_q  <= '0;
      phaseCnt_q <= '0;
      phase_q    <= '0;
      digit_q    <= '0;
    end else begin
      slotCnt_q  <= slotCnt_d;
      phaseCnt_q <= phaseCnt_d;
      phase_q    <= phase_d;
      digit_q    <= digit_d;
    end
  end
endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexes four segment bytes onto one bus with blanking, PWM and
// a per-frame snapshot so a frame never mixes old and new digit values.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] segmentValues,
  input  logic        enable,
  input  logic [3:0]  brightness,
  output logic [3:0]  digitSelect,
  output logic [7:0]  segments,
  output logic        frameStart
);
  localparam logic [3:0] SEL_OFF = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  state_e             state_q, state_d;
  logic [31:0]        shadow_q;
  logic [3:0]         dutyLatched_q;
  logic               loadSnap, slotEntry, run;
  logic               slotStart, slotLast, frameWrap, blankLast, phaseLast;
  logic [3:0]         phase;
  logic [DIGIT_W-1:0] digit;
  logic [3:0]         selDrv;
  logic [7:0]         segDrv;

  assign run = enable && (state_q != IDLE);

  seven_segment_slot_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .run_i       (run),
    .slotStart_o (slotStart),
    .slotLast_o  (slotLast),
    .frameWrap_o (frameWrap),
    .blankLast_o (blankLast),
    .phaseLast_o (phaseLast),
    .phase_o     (phase),
    .digit_o     (digit)
  );

  // Dropping enable beats everything, including a simultaneous frame wrap.
  always_comb begin
    state_d   = state_q;
    loadSnap  = 1'b0;
    slotEntry = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      state_d   = BLANK;
      loadSnap  = 1'b1;
      slotEntry = 1'b1;
    end else if (slotLast) begin
      state_d   = BLANK;
      loadSnap  = frameWrap;
      slotEntry = 1'b1;
    end else if (state_q == BLANK && blankLast) begin
      state_d = DRIVE;
    end else if (state_q == DRIVE && phaseLast && phase == dutyLatched_q) begin
      state_d = DARK;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      dutyLatched_q <= '0;
    end else begin
      state_q <= state_d;
      if (loadSnap)  shadow_q      <= segmentValues;
      if (slotEntry) dutyLatched_q <= brightness;
    end
  end

  always_comb begin
    selDrv = 4'h0;
    segDrv = 8'h00;
    if (state_q == DRIVE) begin
      selDrv = 4'b0001 << digit;
      segDrv = shadow_q[{digit, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digitSelect <= SEL_OFF;
      segments    <= SEG_OFF;
      frameStart  <= 1'b0;
    end else begin
      digitSelect <= selDrv ^ SEL_OFF;
      segments    <= segDrv ^ SEG_OFF;
      frameStart  <= (state_q == BLANK) && slotStart && (digit == '0);
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: frame-position model plus directed and random stimulus.
module tb_seven_segment_scanner;
  localparam int DC = 64;
  localparam int BL = 2;
  localparam int PH = DC / 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] sv  = '0;
  logic [3:0]  br  = '0;
  logic [3:0]  ds0, ds1;
  logic [7:0]  sg0, sg1;
  logic        fs0, fs1;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // model: position within the frame of the cycle the scanner is currently in
  bit          m_run = 1'b0;
  int          m_pos = 0;
  int          m_duty = 0;
  logic [31:0] m_shadow = '0;
  int          m_slot, m_dg, m_ph;
  bit          m_drive;
  logic [3:0]  e_ds = '0;
  logic [7:0]  e_sg = '0;
  logic        e_fs = 1'b0;

  seven_segment_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BL), .ACTIVE_LOW(1'b0)) dut0 (
    .clock(clk), .reset(rst), .segmentValues(sv), .enable(en), .brightness(br),
    .digitSelect(ds0), .segments(sg0), .frameStart(fs0));

  seven_segment_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BL), .ACTIVE_LOW(1'b1)) dut1 (
    .clock(clk), .reset(rst), .segmentValues(sv), .enable(en), .brightness(br),
    .digitSelect(ds1), .segments(sg1), .frameStart(fs1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Pins after an edge reflect the position held before that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_duty = 0; m_shadow = '0;
      e_ds = '0; e_sg = '0; e_fs = 1'b0;
    end else begin
      cyc++;
      m_slot  = m_pos % DC;
      m_dg    = m_pos / DC;
      m_ph    = m_slot / PH;
      m_drive = m_run && (m_slot >= BL) && (m_ph <= m_duty);
      e_ds    = m_drive ? 4'(1 << m_dg) : 4'h0;
      e_sg    = m_drive ? m_shadow[m_dg*8 +: 8] : 8'h00;
      e_fs    = m_run && (m_pos == 0);
      if (!en) begin
        m_run = 1'b0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1'b1; m_pos = 0; m_shadow = sv; m_duty = int'(br);
      end else begin
        m_pos = (m_pos + 1) % (4 * DC);
        if (m_pos % DC == 0) m_duty = int'(br);
        if (m_pos == 0) m_shadow = sv;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pins_al0", {ds0, sg0, fs0}, {e_ds, e_sg, e_fs});
      check("pins_al1", {ds1, sg1, fs1}, {~e_ds, ~e_sg, e_fs});
    end
  end

  task automatic wait_fs(input string name, output int t);
    bit seen = 1'b0;
    t = -1;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (fs0) begin seen = 1'b1; t = cyc; end
      else @(negedge clk);
    end
    if (!seen) timeout(name);
  endtask

  // Counts dark cycles from now, then the length of the following constant drive run.
  task automatic expect_run(input string tag, input int egap, input int elen,
                            input logic [3:0] eds, input logic [7:0] esg);
    int gap = 0;
    int len = 0;
    logic [3:0] rds;
    logic [7:0] rsg;
    while (ds0 == 4'h0 && gap < 400) begin gap++; @(negedge clk); end
    rds = ds0;
    rsg = sg0;
    while (ds0 == rds && sg0 == rsg && len < 400) begin len++; @(negedge clk); end
    check({tag, "_gap"}, gap, egap);
    check({tag, "_len"}, len, elen);
    check({tag, "_sel"}, rds, eds);
    check({tag, "_seg"}, rsg, esg);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t, c0, nfs;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ds0", ds0, 4'h0);
    check("rst_sg0", sg0, 8'h00);
    check("rst_fs0", fs0, 1'b0);
    check("rst_ds1", ds1, 4'hF);
    check("rst_sg1", sg1, 8'hFF);

    // full brightness scan
    sv = 32'h3F06_5B4F; br = 4'd15; en = 1'b1; rst = 1'b0; c0 = cyc;
    wait_fs("fs_first", t0);
    check("fs_first_cycle", t0 - c0, 2);
    expect_run("b15_d0", 2, 62, 4'b0001, 8'h4F);
    expect_run("b15_d1", 2, 62, 4'b0010, 8'h5B);
    expect_run("b15_d2", 2, 62, 4'b0100, 8'h06);
    expect_run("b15_d3", 2, 62, 4'b1000, 8'h3F);
    wait_fs("fs_second", t1);
    check("frame_period", t1 - t0, 256);

    // brightness 3, then 0 changed mid-slot
    br = 4'd3;
    expect_run("late_d0", 2, 62, 4'b0001, 8'h4F);
    expect_run("b3_d1", 2, 14, 4'b0010, 8'h5B);
    fork begin repeat (55) @(negedge clk); br = 4'd0; end join_none
    expect_run("b3_d2", 50, 14, 4'b0100, 8'h06);
    expect_run("b0_d3", 50, 2, 4'b1000, 8'h3F);
    expect_run("b0_d0", 62, 2, 4'b0001, 8'h4F);

    // snapshot holds through a mid-frame value change
    br = 4'd15;
    wait_fs("fs_snap", t);
    expect_run("s_d0", 2, 62, 4'b0001, 8'h4F);
    sv = 32'hFFFF_FFFF;
    expect_run("s_d1", 2, 62, 4'b0010, 8'h5B);
    expect_run("s_d2", 2, 62, 4'b0100, 8'h06);
    expect_run("s_d3", 2, 62, 4'b1000, 8'h3F);
    expect_run("s_new_d0", 2, 62, 4'b0001, 8'hFF);
    expect_run("s_new_d1", 2, 62, 4'b0010, 8'hFF);

    // enable drop while digit 2 is driven
    for (int i = 0; i < 200 && ds0 != 4'b0100; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drop_in_d2", ds0, 4'b0100);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("drop_ds", ds0, 4'h0);
    check("drop_sg", sg0, 8'h00);
    nfs = 0;
    repeat (300) begin @(negedge clk); if (fs0) nfs++; end
    check("drop_no_fs", nfs, 0);
    sv = 32'h1122_3344; c0 = cyc; en = 1'b1;
    wait_fs("fs_reen", t);
    check("reen_fs_cycle", t - c0, 2);
    expect_run("reen_d0", 2, 62, 4'b0001, 8'h44);

    // enable drop exactly on the 3->0 wrap edge
    wait_fs("fs_wrap", t);
    for (int i = 0; i < 400 && cyc != t + 254; i++) @(negedge clk);
    check("wrap_pre_ds", ds0, 4'b1000);
    en = 1'b0;
    nfs = 0;
    repeat (300) begin @(negedge clk); if (fs0) nfs++; end
    check("wrap_no_fs", nfs, 0);

    // random traffic against the model
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      case ($urandom_range(0, 4))
        0, 1: sv = $urandom;
        2:    br = 4'($urandom_range(0, 15));
        3:    en = ~en;
        default: begin sv = $urandom; br = 4'($urandom_range(0, 15)); end
      endcase
    end

    // asynchronous reset in the middle of a drive
    en = 1'b1; br = 4'd15;
    for (int i = 0; i < 600 && ds0 == 4'h0; i++) @(negedge clk);
    check("pre_rst_driving", ds0 != 4'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_ds0", ds0, 4'h0);
    check("arst_sg0", sg0, 8'h00);
    check("arst_fs0", fs0, 1'b0);
    check("arst_ds1", ds1, 4'hF);
    check("arst_sg1", sg1, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
